alu_result_uart_tx: RTL and testbench

- Transmit end of the ALU operand/result path.
- Operands and opcode enter the ALU from switches/buttons. This block takes an ALU result word and sends it out as an asynchronous serial frame (UART, 8N1 by default) on a single line.
- Sits between the ALU output and the board TX pin.
- Uses a valid/ready handshake so the top level can push one result per frame.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_result_uart_tx_baud_tick_gen.sv | 46 ++++
 rtl/alu_result_uart_tx.sv | 149 ++++++++++++++
 tb/tb_alu_result_uart_tx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared widths, default timing and TX FSM state encoding for
//               the ALU datapath and its UART result transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int NB_DATA_DEF      = 8;
    localparam int CLKS_PER_BIT_DEF = 5208;   // 50 MHz / 9600 baud
    localparam int NB_STATE         = 3;

    typedef enum logic [NB_STATE-1:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_result_uart_tx_baud_tick_gen.sv
// ============================================================================
// Module      : baud_tick_gen
// Description : Free-running bit-period counter; o_tick marks the last cycle
//               of each serial bit. i_clear restarts the period.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module baud_tick_gen
    import alu_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int                NB_CNT   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(CLKS_PER_BIT - 1);

    logic [NB_CNT-1:0] cnt_q;
    logic [NB_CNT-1:0] cnt_d;

    always_comb begin
        if (i_clear || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + NB_CNT'(1);
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = (cnt_q == CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/alu_result_uart_tx.sv
// ============================================================================
// Module      : alu_result_uart_tx
// Description : Serialises one ALU result word per valid/ready handshake as an
//               LSB-first UART frame (8N1 by default) on a registered TX line.
//               Define ALU_RESULT_TX_PARITY_EN to insert an even parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_uart_tx
    import alu_pkg::*;
#(
    parameter int NB_DATA      = NB_DATA_DEF,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_valid,
    output logic               o_ready,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_done
);

    localparam int                NB_IDX   = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam logic [NB_IDX-1:0] IDX_LAST = NB_IDX'(NB_DATA - 1);

    tx_state_e          state_q, state_d;
    logic [NB_DATA-1:0] shreg_q, shreg_d;
    logic [NB_IDX-1:0]  idx_q,   idx_d;
    logic               tx_q,    tx_d;
    logic               done_q,  done_d;
    logic               tick;
    logic               baud_clear;
`ifdef ALU_RESULT_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_clear (baud_clear),
        .o_tick  (tick)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        idx_d      = idx_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        baud_clear = 1'b0;
`ifdef ALU_RESULT_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (i_valid) begin
                    state_d    = START;
                    shreg_d    = i_data;
                    idx_d      = '0;
                    tx_d       = 1'b0;
                    baud_clear = 1'b1;
`ifdef ALU_RESULT_TX_PARITY_EN
                    parity_d   = ^i_data;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == IDX_LAST) begin
`ifdef ALU_RESULT_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                        idx_d   = idx_q + NB_IDX'(1);
                    end
                end
            end
`ifdef ALU_RESULT_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Reset drives the line high immediately, aborting any frame in flight.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            idx_q    <= '0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
`ifdef ALU_RESULT_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            idx_q    <= idx_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
`ifdef ALU_RESULT_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_busy  = ~o_ready;
    assign o_tx    = tx_q;
    assign o_done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_result_uart_tx.sv
// ============================================================================
// Module      : tb_alu_result_uart_tx
// Description : Directed self-checking bench for alu_result_uart_tx with
//               CLKS_PER_BIT=4; honours ALU_RESULT_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_result_uart_tx;

    localparam int C = 4;
`ifdef ALU_RESULT_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk;
    logic       i_rst_n;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic       o_tx;
    logic       o_busy;
    logic       o_done;

    int n_checks = 0;
    int n_pass   = 0;

    alu_result_uart_tx #(
        .NB_DATA      (8),
        .CLKS_PER_BIT (C)
    ) dut (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_tx    (o_tx),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Frame layout, bit 0 first on the line: start, data LSB-first, [parity], stop.
    function automatic logic [15:0] exp_frame(input logic [7:0] d);
`ifdef ALU_RESULT_TX_PARITY_EN
        return {5'b0, 1'b1, ^d, d, 1'b0};
`else
        return {6'b0, 1'b1, d, 1'b0};
`endif
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Entered just after the accepting edge; leaves just after edge k+NBITS*C.
    task automatic capture_frame(output logic [15:0] bits, output bit stable,
                                 output int early_done);
        logic first;
        bits       = '0;
        stable     = 1'b1;
        early_done = 0;
        first      = 1'b0;
        for (int b = 0; b < NBITS; b++) begin
            for (int j = 0; j < C; j++) begin
                if (j == 0) first = o_tx;
                else if (o_tx !== first) stable = 1'b0;
                if (j == C / 2) bits[b] = o_tx;
                if (o_done !== 1'b0) early_done++;
                next_cycle();
            end
        end
    endtask

    task automatic send(input logic [7:0] d);
        i_data  = d;
        i_valid = 1'b1;
        next_cycle();
        i_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_data  = 8'h00;
        repeat (3) next_cycle();
        n_checks++; if (o_tx !== 1'b1)    $display("FAIL reset_tx: got %b want 1", o_tx);       else n_pass++;
        n_checks++; if (o_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", o_ready); else n_pass++;
        n_checks++; if (o_busy !== 1'b0)  $display("FAIL reset_busy: got %b want 0", o_busy);   else n_pass++;
        n_checks++; if (o_done !== 1'b0)  $display("FAIL reset_done: got %b want 0", o_done);   else n_pass++;
        i_rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_idle();
        int bad_tx, bad_rdy, bad_busy, bad_done;
        bad_tx = 0; bad_rdy = 0; bad_busy = 0; bad_done = 0;
        for (int i = 0; i < 100; i++) begin
            if (o_tx !== 1'b1)    bad_tx++;
            if (o_ready !== 1'b1) bad_rdy++;
            if (o_busy !== 1'b0)  bad_busy++;
            if (o_done !== 1'b0)  bad_done++;
            next_cycle();
        end
        n_checks++; if (bad_tx != 0)   $display("FAIL idle_tx: %0d cycles low, want 0", bad_tx);          else n_pass++;
        n_checks++; if (bad_rdy != 0)  $display("FAIL idle_ready: %0d cycles not ready, want 0", bad_rdy); else n_pass++;
        n_checks++; if (bad_busy != 0) $display("FAIL idle_busy: %0d cycles busy, want 0", bad_busy);     else n_pass++;
        n_checks++; if (bad_done != 0) $display("FAIL idle_done: %0d pulses, want 0", bad_done);          else n_pass++;
    endtask

    task automatic test_single_a5();
        logic [15:0] bits;
        bit          stable;
        int          early;
        send(8'hA5);
        n_checks++; if (o_ready !== 1'b0) $display("FAIL a5_ready_after_accept: got %b want 0", o_ready); else n_pass++;
        n_checks++; if (o_busy !== 1'b1)  $display("FAIL a5_busy_after_accept: got %b want 1", o_busy);   else n_pass++;
        capture_frame(bits, stable, early);
`ifndef ALU_RESULT_TX_PARITY_EN
        n_checks++; if (bits[9:0] !== 10'h34A) $display("FAIL a5_bits: got %h want 34a", bits[9:0]); else n_pass++;
`endif
        n_checks++; if (bits !== exp_frame(8'hA5)) $display("FAIL a5_frame: got %h want %h", bits, exp_frame(8'hA5)); else n_pass++;
        n_checks++; if (bits[8:1] !== 8'hA5) $display("FAIL a5_reconstruct: got %h want a5", bits[8:1]); else n_pass++;
        n_checks++; if (!stable)    $display("FAIL a5_bit_hold: got unstable want stable");       else n_pass++;
        n_checks++; if (early != 0) $display("FAIL a5_early_done: got %0d want 0", early);       else n_pass++;
        n_checks++; if (o_done !== 1'b1)  $display("FAIL a5_done_pulse: got %b want 1", o_done);   else n_pass++;
        n_checks++; if (o_ready !== 1'b1) $display("FAIL a5_ready_end: got %b want 1", o_ready);   else n_pass++;
        next_cycle();
        n_checks++; if (o_done !== 1'b0)  $display("FAIL a5_done_width: got %b want 0", o_done);   else n_pass++;
        n_checks++; if (o_tx !== 1'b1)    $display("FAIL a5_idle_after: got %b want 1", o_tx);     else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits;
        bit          stable;
        int          early;
        i_data  = 8'hFD;
        i_valid = 1'b1;
        next_cycle();
        i_data  = 8'h00;
        capture_frame(bits, stable, early);
        n_checks++; if (bits !== exp_frame(8'hFD)) $display("FAIL b2b_frame1: got %h want %h", bits, exp_frame(8'hFD)); else n_pass++;
        n_checks++; if (!stable || early != 0) $display("FAIL b2b_frame1_timing: stable=%0d early=%0d want 1/0", stable, early); else n_pass++;
        n_checks++; if (o_done !== 1'b1 || o_ready !== 1'b1) $display("FAIL b2b_gap: done=%b ready=%b want 1/1", o_done, o_ready); else n_pass++;
        n_checks++; if (o_tx !== 1'b1) $display("FAIL b2b_gap_tx: got %b want 1", o_tx); else n_pass++;
        i_data = 8'hFD;
        next_cycle();
        i_valid = 1'b0;
        n_checks++; if (o_tx !== 1'b0 || o_ready !== 1'b0) $display("FAIL b2b_second_start: tx=%b ready=%b want 0/0", o_tx, o_ready); else n_pass++;
        capture_frame(bits, stable, early);
        n_checks++; if (bits !== exp_frame(8'hFD)) $display("FAIL b2b_frame2: got %h want %h", bits, exp_frame(8'hFD)); else n_pass++;
        n_checks++; if (o_done !== 1'b1) $display("FAIL b2b_done2: got %b want 1", o_done); else n_pass++;
        next_cycle();
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] bits;
        bit          stable;
        int          early;
        send(8'hA5);
        repeat (17) next_cycle();
        n_checks++; if (o_tx !== 1'b0) $display("FAIL rst_mid_pre_tx: got %b want 0", o_tx); else n_pass++;
        i_rst_n = 1'b0;
        #1;
        n_checks++; if (o_tx !== 1'b1)    $display("FAIL rst_mid_tx: got %b want 1", o_tx);       else n_pass++;
        n_checks++; if (o_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b want 1", o_ready); else n_pass++;
        next_cycle();
        i_rst_n = 1'b1;
        next_cycle();
        n_checks++; if (o_ready !== 1'b1 || o_tx !== 1'b1) $display("FAIL rst_mid_release: ready=%b tx=%b want 1/1", o_ready, o_tx); else n_pass++;
        send(8'h3C);
        capture_frame(bits, stable, early);
        n_checks++; if (bits !== exp_frame(8'h3C)) $display("FAIL rst_mid_frame_3c: got %h want %h", bits, exp_frame(8'h3C)); else n_pass++;
        n_checks++; if (o_done !== 1'b1) $display("FAIL rst_mid_done: got %b want 1", o_done); else n_pass++;
        next_cycle();
    endtask

    task automatic test_valid_in_done_cycle();
        logic [15:0] bits;
        bit          stable;
        int          early;
        send(8'h81);
        capture_frame(bits, stable, early);
        n_checks++; if (o_done !== 1'b1) $display("FAIL donecyc_done: got %b want 1", o_done); else n_pass++;
        i_data  = 8'h01;
        i_valid = 1'b1;
        next_cycle();
        i_valid = 1'b0;
        n_checks++; if (o_ready !== 1'b0 || o_tx !== 1'b0) $display("FAIL donecyc_accept: ready=%b tx=%b want 0/0", o_ready, o_tx); else n_pass++;
        capture_frame(bits, stable, early);
        n_checks++; if (bits !== exp_frame(8'h01)) $display("FAIL donecyc_frame: got %h want %h", bits, exp_frame(8'h01)); else n_pass++;
        n_checks++; if (o_done !== 1'b1) $display("FAIL donecyc_done2: got %b want 1", o_done); else n_pass++;
        next_cycle();
    endtask

`ifdef ALU_RESULT_TX_PARITY_EN
    task automatic test_parity();
        logic [15:0] bits;
        bit          stable;
        int          early;
        send(8'hA5);
        capture_frame(bits, stable, early);
        n_checks++; if (bits[10:0] !== 11'h54A) $display("FAIL par_a5_frame: got %h want 54a", bits[10:0]); else n_pass++;
        n_checks++; if (bits[9] !== 1'b0) $display("FAIL par_a5_bit: got %b want 0", bits[9]); else n_pass++;
        n_checks++; if (o_done !== 1'b1 || early != 0) $display("FAIL par_a5_done44: done=%b early=%0d want 1/0", o_done, early); else n_pass++;
        next_cycle();
        send(8'h07);
        capture_frame(bits, stable, early);
        n_checks++; if (bits[10:0] !== 11'h60E) $display("FAIL par_07_frame: got %h want 60e", bits[10:0]); else n_pass++;
        n_checks++; if (bits[9] !== 1'b1) $display("FAIL par_07_bit: got %b want 1", bits[9]); else n_pass++;
        next_cycle();
    endtask
`endif

    initial begin
        test_reset();
        test_idle();
        test_single_a5();
        test_back_to_back();
        test_reset_mid_frame();
        test_valid_in_done_cycle();
`ifdef ALU_RESULT_TX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
